// File: rtl/arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package arb_pkg;

  localparam int ARB_WAIT_CYCLES = 4;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    IF_ACC  = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_IF     = 2'd0,
    GNT_MEM_RD = 2'd1,
    GNT_MEM_WR = 2'd2
  } arb_gnt_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Loadable down-counter that paces one SRAM access; zero marks the last cycle.
module arb_wait_counter
  import arb_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port SRAM between the fetch and memory
// stages. The memory stage has fixed priority because its instruction is older.
// Optional stall counters are built when ARB_PERF_CNT_EN is defined.
//
// state   | meaning
// IDLE    | no access; sample requests, memory stage first
// MEM_ACC | memory-stage load or store in progress
// IF_ACC  | fetch read in progress
// DONE    | one-cycle ready pulse to the granted requester
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int WAIT_CYCLES = ARB_WAIT_CYCLES,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              freeze_if,
  output logic              freeze_pipe,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic [31:0]       if_stall_cnt,
  output logic [31:0]       mem_stall_cnt
);

  arb_state_e        state_q, state_d;
  arb_gnt_e          gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              cnt_load;
  logic              cnt_zero;
  logic              in_access;
  logic [CNT_W-1:0]  cnt_val;

  // Byte offset and bits above the SRAM word range do not reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0], cnt_val};

  assign in_access = (state_q == MEM_ACC) || (state_q == IF_ACC);

  arb_wait_counter #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .dec      (in_access),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // Next state, grant latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    cnt_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_wr_req || mem_rd_req) begin
          state_d  = MEM_ACC;
          gnt_d    = mem_wr_req ? GNT_MEM_WR : GNT_MEM_RD;
          addr_d   = mem_addr[ADDR_W+1:2];
          wdata_d  = mem_wdata;
          cnt_load = 1'b1;
        end else if (if_req) begin
          state_d  = IF_ACC;
          gnt_d    = GNT_IF;
          addr_d   = if_addr[ADDR_W+1:2];
          cnt_load = 1'b1;
        end
      end
      MEM_ACC, IF_ACC: begin
        if (cnt_zero) begin
          state_d = DONE;
          if (gnt_q == GNT_IF)          if_rdata_d  = sram_rdata;
          else if (gnt_q == GNT_MEM_RD) mem_rdata_d = sram_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Strobes decode straight from the state flop so reset removes them at once.
  assign sram_en    = in_access;
  assign sram_we    = in_access && (gnt_q == GNT_MEM_WR);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  assign if_ready   = (state_q == DONE) && (gnt_q == GNT_IF);
  assign mem_ready  = (state_q == DONE) && (gnt_q != GNT_IF);
  assign if_rdata   = if_rdata_q;
  assign mem_rdata  = mem_rdata_q;

  assign freeze_pipe = (mem_rd_req | mem_wr_req) & ~mem_ready;
  assign freeze_if   = freeze_pipe | (if_req & ~if_ready);

`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_stall_q, if_stall_d;
  logic [31:0] mem_stall_q, mem_stall_d;

  // Free-running stall counters, wrapping naturally at 2^32.
  always_comb begin
    if_stall_d  = if_stall_q + {31'd0, freeze_if};
    mem_stall_d = mem_stall_q + {31'd0, freeze_pipe};
  end

  // Stall counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_stall_q  <= '0;
      mem_stall_q <= '0;
    end else begin
      if_stall_q  <= if_stall_d;
      mem_stall_q <= mem_stall_d;
    end
  end

  assign if_stall_cnt  = if_stall_q;
  assign mem_stall_cnt = mem_stall_q;
`else
  assign if_stall_cnt  = '0;
  assign mem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed test-plan steps followed by
// random isolated transactions checked against a word-level memory model.
module tb_mem_port_arbiter;

  localparam int WAIT   = 4;
  localparam int ADDR_W = 16;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ready;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic              freeze_if;
  logic              freeze_pipe;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic [31:0]       if_stall_cnt;
  logic [31:0]       mem_stall_cnt;

  mem_port_arbiter #(.WAIT_CYCLES(WAIT), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_ready      (if_ready),
    .mem_rd_req    (mem_rd_req),
    .mem_wr_req    (mem_wr_req),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .freeze_if     (freeze_if),
    .freeze_pipe   (freeze_pipe),
    .sram_en       (sram_en),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .if_stall_cnt  (if_stall_cnt),
    .mem_stall_cnt (mem_stall_cnt)
  );

  always #5 clk = ~clk;

  // SRAM behavioural model driven by the DUT; read data is junk outside an access.
  logic [31:0] sram_mem [0:65535];
  assign sram_rdata = sram_en ? sram_mem[sram_addr] : 32'hDEAD_BEEF;
  always @(posedge clk) if (sram_en && sram_we) sram_mem[sram_addr] <= sram_wdata;

  // Reference contents, updated only from the bench's own transactions.
  logic [31:0] ref_mem [0:65535];
  logic [31:0] exp_if_rdata, exp_mem_rdata;
  int          exp_if_cnt, exp_mem_cnt;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pat(input int w);
    logic [31:0] v;
    v = w;
    return {v[15:0] ^ 16'h5A3C, ~v[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_if_stall"},  if_stall_cnt,  PERF ? exp_if_cnt  : 0);
    chk({tag, "_mem_stall"}, mem_stall_cnt, PERF ? exp_mem_cnt : 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_mem_rdata"}, mem_rdata, 0);
    chk({tag, "_ready"},     {if_ready, mem_ready}, 0);
    chk({tag, "_sram_ctl"},  {sram_en, sram_we}, 0);
    chk({tag, "_sram_addr"}, sram_addr, 0);
    chk({tag, "_sram_wd"},   sram_wdata, 0);
    chk({tag, "_stall_if"},  if_stall_cnt, 0);
    chk({tag, "_stall_mem"}, mem_stall_cnt, 0);
  endtask

  // One isolated transaction: 0 fetch, 1 load, 2 store, 3 load+store (store wins).
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [31:0] wd);
    logic [ADDR_W-1:0] word;
    bit is_if, is_wr;
    int k;
    word  = addr[ADDR_W+1:2];
    is_if = (kind == 0);
    is_wr = (kind >= 2);
    @(posedge clk); #1;
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_rd_req = (kind == 1) || (kind == 3);
      mem_wr_req = is_wr;
      mem_addr   = addr;
      mem_wdata  = wd;
    end
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (is_if ? if_ready : mem_ready) break;
      chk("freeze_if_busy", freeze_if, 1);
      chk("freeze_pipe_busy", freeze_pipe, !is_if);
      if (k >= 1 && k <= WAIT) begin
        chk("sram_en_acc", sram_en, 1);
        chk("sram_we_acc", sram_we, is_wr);
        chk("sram_addr_acc", sram_addr, word);
        if (is_wr) chk("sram_wdata_acc", sram_wdata, wd);
      end else begin
        chk("sram_en_idle", sram_en, 0);
      end
    end
    chk("latency", k, WAIT + 1);
    chk("other_ready", is_if ? mem_ready : if_ready, 0);
    chk("sram_en_done", sram_en, 0);
    if (is_if) begin
      chk("freeze_if_at_ready", freeze_if, 0);
      exp_if_rdata = ref_mem[word];
      exp_if_cnt  += WAIT + 1;
    end else begin
      chk("freeze_pipe_at_ready", freeze_pipe, 0);
      if (is_wr) ref_mem[word] = wd;
      else       exp_mem_rdata = ref_mem[word];
      exp_if_cnt  += WAIT + 1;
      exp_mem_cnt += WAIT + 1;
    end
    chk("if_rdata", if_rdata, exp_if_rdata);
    chk("mem_rdata", mem_rdata, exp_mem_rdata);
    @(posedge clk); #1;
    if_req = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", {if_ready, mem_ready}, 0);
    chk("freeze_after", {freeze_if, freeze_pipe}, 0);
  endtask

  // Fetch and load both pending; the load is raised in cycle mem_start.
  task automatic two_req(input int mem_start, input int exp_ir, input int exp_mr,
                         input logic [31:0] ia, input logic [31:0] ma);
    int ir, mr, mpulse, ipulse;
    ir = -1; mr = -1; mpulse = 0; ipulse = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = ia; mem_addr = ma;
    mem_rd_req = (mem_start == 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_ready) begin mpulse++; if (mr < 0) mr = k; end
      if (if_ready)  begin ipulse++; if (ir < 0) ir = k; end
      if (ir >= 0 && mr >= 0) break;
      @(posedge clk); #1;
      if (mem_ready) mem_rd_req = 1'b0;
      if (if_ready)  if_req = 1'b0;
      if (k + 1 == mem_start) mem_rd_req = 1'b1;
    end
    chk("pair_if_ready_cycle", ir, exp_ir);
    chk("pair_mem_ready_cycle", mr, exp_mr);
    chk("pair_pulses", {ipulse[15:0], mpulse[15:0]}, {16'd1, 16'd1});
    exp_if_rdata  = ref_mem[ia[ADDR_W+1:2]];
    exp_mem_rdata = ref_mem[ma[ADDR_W+1:2]];
    chk("pair_if_rdata", if_rdata, exp_if_rdata);
    chk("pair_mem_rdata", mem_rdata, exp_mem_rdata);
    @(posedge clk); #1;
    if_req = 1'b0; mem_rd_req = 1'b0;
  endtask

  initial begin
    int k;
    logic [31:0] r, a, d;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = pat(i);
      ref_mem[i]  = pat(i);
    end
    sram_mem[2] = 32'hE3A0_0014;
    ref_mem[2]  = 32'hE3A0_0014;
    rst = 1'b1;
    if_req = 0; if_addr = 0; mem_rd_req = 0; mem_wr_req = 0; mem_addr = 0; mem_wdata = 0;
    exp_if_rdata = 0; exp_mem_rdata = 0; exp_if_cnt = 0; exp_mem_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Test-plan fetch and store.
    run_txn(0, 32'h0000_0008, 32'h0);
    chk("fetch_word", if_rdata, 32'hE3A0_0014);
    run_txn(2, 32'h0000_0400, 32'h0000_2000);
    chk("store_in_sram", sram_mem[16'h100], 32'h0000_2000);
    run_txn(1, 32'h0000_0400, 32'h0);
    chk("load_back", mem_rdata, 32'h0000_2000);

    // Simultaneous request: memory first, fetch regranted after DONE and IDLE.
    two_req(0, 2 * WAIT + 3, WAIT + 1, 32'h0000_0010, 32'h0000_0020);
    // Load arriving mid-fetch waits for the fetch to finish.
    two_req(2, WAIT + 1, 2 * WAIT + 3, 32'h0000_0030, 32'h0000_0044);

    // Reset two cycles into a store.
    @(posedge clk); #1;
    mem_wr_req = 1'b1; mem_addr = 32'h0000_00C0; mem_wdata = 32'hCAFE_0001;
    repeat (3) @(negedge clk);
    chk("pre_rst_ctl", {sram_en, sram_we}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rst_async_ctl", {sram_en, sram_we}, 0);
    exp_if_rdata = 0; exp_mem_rdata = 0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_ready", mem_ready, 0);
    end
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    rst = 1'b0;
    for (k = 0; k < 30; k++) begin
      if (mem_ready) break;
      @(negedge clk);
    end
    chk("regrant_latency", k, WAIT + 1);
    ref_mem[16'h30] = 32'hCAFE_0001;
    @(posedge clk); #1;
    mem_wr_req = 1'b0;
    run_txn(1, 32'h0000_00C0, 32'h0);
    chk("regrant_store_data", mem_rdata, 32'hCAFE_0001);

    // Clean reset, then stall counters over a fetch and a load.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset2");
    rst = 1'b0;
    exp_if_rdata = 0; exp_mem_rdata = 0; exp_if_cnt = 0; exp_mem_cnt = 0;
    run_txn(0, 32'h0000_0104, 32'h0);
    chk_counters("after_fetch");
    run_txn(1, 32'h0000_0208, 32'h0);
    chk_counters("after_load");

    // Random isolated transactions.
    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      a = (r & 32'hFFFC_0003) | ($urandom_range(0, 63) << 2);
      d = $urandom();
      run_txn($urandom_range(0, 3), a, d);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    chk_counters("random_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
